decision_scheduler: RTL and testbench
=====================================

Name: decision_scheduler

Overview:
- Sequences the random-literal picker for the DPLL decision step.
- On a decision request from the DPLL core, it enables the picker and qualifies each candidate against the live assignment vector.
- After MAX_TRIES failed random draws it falls back to a deterministic linear scan.
- Returns the chosen variable and its polarity, or a "no unassigned variable" result, over a valid/ready handshake.

Parameters:
- WIDTH, 8, variable index width; equals picker WIDTH.
- N, 256, number of variable slots (2**WIDTH); index 0 is unused because the LFSR never produces 0.
- MAX_TRIES, 16, random draws attempted before scan fallback; legal range 1..255.
- DEFAULT_POL, 0, polarity reported for scan-selected variables.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- lit_assigned  in  N  bit i = 1 means variable i is assigned.
- dec_req  in  1  core requests a decision (level; sampled only in IDLE).
- dec_abort  in  1  backtrack/abort; cancels any request in flight.
- dec_ready  in  1  core accepts the result.
- pick_val_in  in  WIDTH  candidate from picker (rand_val_out).
- pick_valid_in  in  1  picker valid_out.
- pick_ena  out  1  enable to picker.
- dec_valid  out  1  result available.
- dec_var  out  WIDTH  chosen variable index.
- dec_pol  out  1  chosen polarity.
- dec_none  out  1  qualifies dec_valid: every variable 1..N-1 is assigned.
- busy  out  1  state != IDLE.
- fallback_cnt  out  8  saturating count of scan fallbacks.

Behaviour:
- Reset (async assert, sync release): state=IDLE; try_cnt=0; scan_idx=1; all outputs 0; fallback_cnt=0.
- all_set = AND of lit_assigned[N-1:1]. It is combinational from the live vector.
- IDLE:
  - pick_ena=0.
  - On dec_req with all_set=1, go to NONE.
  - On dec_req with all_set=0, go to RAND and clear try_cnt.
- RAND:
  - pick_ena=1 every cycle in this state.
  - A hit is pick_valid_in=1 AND pick_val_in!=0 AND lit_assigned[pick_val_in]=0. The re-check against the live vector is mandatory because the picker's valid lags by one cycle.
  - On a hit: latch dec_var=pick_val_in and dec_pol=pick_val_in[WIDTH-1], then go to HOLD.
  - Otherwise increment try_cnt. The first RAND cycle counts as a try even though picker valid is still stale.
  - When try_cnt==MAX_TRIES-1 with no hit: go to SCAN, set scan_idx=1, and increment fallback_cnt, saturating at 255.
- SCAN:
  - pick_ena=0. One index is examined per cycle.
  - If lit_assigned[scan_idx]=0: dec_var=scan_idx, dec_pol=DEFAULT_POL, go to HOLD.
  - Else if scan_idx==N-1: go to NONE.
  - Else increment scan_idx. Worst-case latency is N-1 cycles.
- HOLD:
  - dec_valid=1 and dec_none=0. dec_var and dec_pol stay stable while dec_valid=1 and dec_ready=0.
  - On dec_ready: go to IDLE. dec_valid falls on the next cycle.
- NONE:
  - dec_valid=1 and dec_none=1; dec_var=0.
  - On dec_ready: go to IDLE.
- dec_abort has priority over every transition. From any state it goes to IDLE on the next edge: dec_valid=0, pick_ena=0, try_cnt cleared. fallback_cnt is untouched.
- dec_req held high after a handshake starts a new decision on the cycle after the return to IDLE. There are no back-to-back results in the same cycle.
- Minimum latency from dec_req sampled to dec_valid is 3 cycles: IDLE→RAND, picker register, hit→HOLD.
- lit_assigned changing mid-RAND or mid-SCAN is legal; only the live vector is used for qualification.
- The picker's own reset/seed is outside this block. The scheduler never resets the picker.

Test Plan:
- Reset mid-HOLD: assert rst_n=0 while dec_valid=1 → all outputs 0 asynchronously; state IDLE after release.
- lit_assigned=0, dec_req=1, picker returns 3 with valid → dec_valid=1, dec_var=3, dec_pol=0 three cycles after the request; hold with dec_ready=0 for 5 cycles → dec_var stays 3.
- MAX_TRIES=4, lit_assigned all ones except bit 9, picker never yields 9:
  - Exactly 4 RAND cycles with pick_ena=1.
  - SCAN finds 9 (scan_idx 1..9 takes 9 cycles).
  - Result dec_var=9, dec_pol=DEFAULT_POL, fallback_cnt=1.
- lit_assigned bits 1..N-1 all 1, dec_req → dec_valid=1, dec_none=1 on the cycle after the request; dec_ready → IDLE.
- Picker offers 5 with valid=1 while lit_assigned[5] rises in the same cycle → no hit, try_cnt increments, scheduler stays in RAND.
- dec_abort pulsed during SCAN at scan_idx=40 → IDLE next cycle, dec_valid never asserted; a new dec_req restarts in RAND with try_cnt=0.

Source files
------------

// File: rtl/decision_scheduler.sv
// DPLL decision sequencer: random literal draws with a deterministic scan fallback.
// Returns the chosen variable and polarity over a valid/ready handshake.
module decision_scheduler #(
    parameter int   WIDTH       = 8,
    parameter int   N           = 256,
    parameter int   MAX_TRIES   = 16,
    parameter logic DEFAULT_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     lit_assigned,
    input  logic             dec_req,
    input  logic             dec_abort,
    input  logic             dec_ready,
    input  logic [WIDTH-1:0] pick_val_in,
    input  logic             pick_valid_in,
    output logic             pick_ena,
    output logic             dec_valid,
    output logic [WIDTH-1:0] dec_var,
    output logic             dec_pol,
    output logic             dec_none,
    output logic             busy,
    output logic [7:0]       fallback_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAND,
        S_SCAN,
        S_HOLD,
        S_NONE
    } state_e;

    localparam logic [7:0]       LAST_TRY = 8'(MAX_TRIES - 1);
    localparam logic [WIDTH-1:0] LAST_IDX = WIDTH'(N - 1);
    localparam logic [WIDTH-1:0] IDX_ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [7:0]       try_cnt_q, try_cnt_d;
    logic [WIDTH-1:0] scan_idx_q, scan_idx_d;
    logic [WIDTH-1:0] var_q, var_d;
    logic             pol_q, pol_d;
    logic [7:0]       fb_q, fb_d;

    logic all_set;
    logic hit;
    logic scan_free;

    // Qualification always uses the live vector; the picker's valid lags a cycle.
    assign all_set   = &lit_assigned[N-1:1];
    assign hit       = pick_valid_in && (pick_val_in != '0) && !lit_assigned[pick_val_in];
    assign scan_free = !lit_assigned[scan_idx_q];

    always_comb begin
        state_d    = state_q;
        try_cnt_d  = try_cnt_q;
        scan_idx_d = scan_idx_q;
        var_d      = var_q;
        pol_d      = pol_q;
        fb_d       = fb_q;
        if (dec_abort) begin
            state_d   = S_IDLE;
            try_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (dec_req && all_set) begin
                        state_d = S_NONE;
                        var_d   = '0;
                        pol_d   = 1'b0;
                    end else if (dec_req) begin
                        state_d   = S_RAND;
                        try_cnt_d = '0;
                    end
                end
                S_RAND: begin
                    if (hit) begin
                        state_d = S_HOLD;
                        var_d   = pick_val_in;
                        pol_d   = pick_val_in[WIDTH-1];
                    end else begin
                        try_cnt_d = try_cnt_q + 8'd1;
                        if (try_cnt_q == LAST_TRY) begin
                            state_d    = S_SCAN;
                            scan_idx_d = IDX_ONE;
                            if (fb_q != 8'hff) fb_d = fb_q + 8'd1;
                        end
                    end
                end
                S_SCAN: begin
                    if (scan_free) begin
                        state_d = S_HOLD;
                        var_d   = scan_idx_q;
                        pol_d   = DEFAULT_POL;
                    end else if (scan_idx_q == LAST_IDX) begin
                        state_d = S_NONE;
                        var_d   = '0;
                        pol_d   = 1'b0;
                    end else begin
                        scan_idx_d = scan_idx_q + IDX_ONE;
                    end
                end
                S_HOLD, S_NONE: begin
                    if (dec_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            try_cnt_q  <= '0;
            scan_idx_q <= IDX_ONE;
            var_q      <= '0;
            pol_q      <= 1'b0;
            fb_q       <= '0;
        end else begin
            state_q    <= state_d;
            try_cnt_q  <= try_cnt_d;
            scan_idx_q <= scan_idx_d;
            var_q      <= var_d;
            pol_q      <= pol_d;
            fb_q       <= fb_d;
        end
    end

    assign pick_ena     = (state_q == S_RAND);
    assign dec_valid    = (state_q == S_HOLD) || (state_q == S_NONE);
    assign dec_none     = (state_q == S_NONE);
    assign busy         = (state_q != S_IDLE);
    assign dec_var      = var_q;
    assign dec_pol      = pol_q;
    assign fallback_cnt = fb_q;

endmodule

// File: tb/tb_decision_scheduler.sv
// Directed bench for decision_scheduler with a small registered picker model.
module tb_decision_scheduler;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] lit;
    logic         dec_req, dec_abort, dec_ready;
    logic [7:0]   pick_val_in;
    logic         pick_valid_in;
    logic         pick_ena, dec_valid, dec_pol, dec_none, busy;
    logic [7:0]   dec_var, fallback_cnt;
    logic [7:0]   pick_next;

    int n_chk = 0;
    int n_fail = 0;
    int exp_fb = 0;

    always #5 clk = ~clk;

    decision_scheduler #(
        .WIDTH(8), .N(256), .MAX_TRIES(4), .DEFAULT_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .lit_assigned(lit),
        .dec_req(dec_req), .dec_abort(dec_abort), .dec_ready(dec_ready),
        .pick_val_in(pick_val_in), .pick_valid_in(pick_valid_in),
        .pick_ena(pick_ena), .dec_valid(dec_valid), .dec_var(dec_var),
        .dec_pol(dec_pol), .dec_none(dec_none), .busy(busy),
        .fallback_cnt(fallback_cnt)
    );

    // Picker stand-in: valid follows enable by one cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pick_valid_in <= 1'b0;
            pick_val_in   <= 8'd0;
        end else begin
            pick_valid_in <= pick_ena;
            if (pick_ena) pick_val_in <= pick_next;
        end
    end

    task automatic test_reset;
        rst_n = 1'b0;
        #2;
        n_chk++;
        if ({busy, pick_ena, dec_valid, dec_none} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000", {busy, pick_ena, dec_valid, dec_none});
        end
        n_chk++;
        if (fallback_cnt !== 8'd0 || dec_var !== 8'd0 || dec_pol !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_regs: got fb=%0d var=%0d pol=%0d want 0", fallback_cnt, dec_var, dec_pol);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic handshake(input string nm);
        dec_ready = 1'b1;
        @(negedge clk);
        dec_ready = 1'b0;
        n_chk++;
        if (busy !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_release: got busy=%b valid=%b want 0 0", nm, busy, dec_valid);
        end
    endtask

    task automatic test_hit_hold;
        lit = '0;
        pick_next = 8'd3;
        dec_req = 1'b1;
        @(negedge clk);
        dec_req = 1'b0;
        n_chk++;
        if (dec_valid !== 1'b0 || pick_ena !== 1'b1) begin
            n_fail++;
            $display("FAIL hit_c1: got valid=%b ena=%b want 0 1", dec_valid, pick_ena);
        end
        @(negedge clk);
        n_chk++;
        if (dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_c2: got valid=%b want 0", dec_valid);
        end
        @(negedge clk);
        n_chk++;
        if (dec_valid !== 1'b1 || dec_var !== 8'd3 || dec_pol !== 1'b0 || dec_none !== 1'b0) begin
            n_fail++;
            $display("FAIL hit_c3: got v=%b var=%0d pol=%b none=%b want 1 3 0 0",
                     dec_valid, dec_var, dec_pol, dec_none);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if (dec_valid !== 1'b1 || dec_var !== 8'd3) begin
                n_fail++;
                $display("FAIL hit_hold%0d: got v=%b var=%0d want 1 3", i, dec_valid, dec_var);
            end
        end
        handshake("hit");
    endtask

    task automatic test_fallback;
        int rc, sc;
        bit got;
        rc = 0; sc = 0; got = 0;
        lit = '1;
        lit[9] = 1'b0;
        pick_next = 8'd200;
        dec_req = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            dec_req = 1'b0;
            if (dec_valid) begin got = 1; break; end
            if (pick_ena) rc++;
            else if (busy) sc++;
        end
        exp_fb++;
        n_chk++;
        if (!got || rc != 4 || sc != 9) begin
            n_fail++;
            $display("FAIL fb_timing: got done=%0d rand=%0d scan=%0d want 1 4 9", got, rc, sc);
        end
        n_chk++;
        if (dec_var !== 8'd9 || dec_pol !== 1'b0 || dec_none !== 1'b0) begin
            n_fail++;
            $display("FAIL fb_result: got var=%0d pol=%b none=%b want 9 0 0", dec_var, dec_pol, dec_none);
        end
        n_chk++;
        if (fallback_cnt !== 8'(exp_fb)) begin
            n_fail++;
            $display("FAIL fb_count: got %0d want %0d", fallback_cnt, exp_fb);
        end
        handshake("fb");
    endtask

    task automatic test_none;
        lit = '1;
        dec_req = 1'b1;
        @(negedge clk);
        dec_req = 1'b0;
        n_chk++;
        if (dec_valid !== 1'b1 || dec_none !== 1'b1 || dec_var !== 8'd0) begin
            n_fail++;
            $display("FAIL none: got v=%b none=%b var=%0d want 1 1 0", dec_valid, dec_none, dec_var);
        end
        handshake("none");
    endtask

    task automatic test_live_recheck;
        int rc, sc;
        bit got;
        rc = 0; sc = 0; got = 0;
        lit = '0;
        pick_next = 8'd5;
        dec_req = 1'b1;
        @(negedge clk);
        dec_req = 1'b0;
        @(posedge clk);
        #1 lit[5] = 1'b1;
        @(negedge clk);
        n_chk++;
        if (pick_ena !== 1'b1 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL live_c2: got ena=%b v=%b want 1 0", pick_ena, dec_valid);
        end
        @(negedge clk);
        n_chk++;
        if (pick_ena !== 1'b1 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL live_stay: got ena=%b v=%b want 1 0", pick_ena, dec_valid);
        end
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dec_valid) begin got = 1; break; end
            if (pick_ena) rc++;
            else if (busy) sc++;
        end
        exp_fb++;
        n_chk++;
        if (!got || rc != 1 || sc != 1 || dec_var !== 8'd1 || dec_pol !== 1'b0) begin
            n_fail++;
            $display("FAIL live_result: got done=%0d rand=%0d scan=%0d var=%0d pol=%b want 1 1 1 1 0",
                     got, rc, sc, dec_var, dec_pol);
        end
        n_chk++;
        if (fallback_cnt !== 8'(exp_fb)) begin
            n_fail++;
            $display("FAIL live_fb: got %0d want %0d", fallback_cnt, exp_fb);
        end
        handshake("live");
    endtask

    task automatic test_abort;
        int rc, sc;
        bit seen, got;
        rc = 0; sc = 0; seen = 0; got = 0;
        lit = '1;
        lit[100] = 1'b0;
        pick_next = 8'd7;
        dec_req = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            dec_req = 1'b0;
            if (dec_valid) seen = 1;
            if (pick_ena) rc++;
            else if (busy) sc++;
            if (sc == 40) begin dec_abort = 1'b1; break; end
        end
        @(negedge clk);
        dec_abort = 1'b0;
        exp_fb++;
        n_chk++;
        if (busy !== 1'b0 || dec_valid !== 1'b0 || pick_ena !== 1'b0 || seen || sc != 40) begin
            n_fail++;
            $display("FAIL abort_idle: got busy=%b v=%b ena=%b seen=%0d scan=%0d want 0 0 0 0 40",
                     busy, dec_valid, pick_ena, seen, sc);
        end
        n_chk++;
        if (fallback_cnt !== 8'(exp_fb)) begin
            n_fail++;
            $display("FAIL abort_fb: got %0d want %0d", fallback_cnt, exp_fb);
        end
        rc = 0; sc = 0;
        dec_req = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            dec_req = 1'b0;
            if (dec_valid) begin got = 1; break; end
            if (pick_ena) rc++;
            else if (busy) sc++;
        end
        exp_fb++;
        n_chk++;
        if (!got || rc != 4 || sc != 100) begin
            n_fail++;
            $display("FAIL restart_timing: got done=%0d rand=%0d scan=%0d want 1 4 100", got, rc, sc);
        end
        n_chk++;
        if (dec_var !== 8'd100 || dec_pol !== 1'b0 || fallback_cnt !== 8'(exp_fb)) begin
            n_fail++;
            $display("FAIL restart_result: got var=%0d pol=%b fb=%0d want 100 0 %0d",
                     dec_var, dec_pol, fallback_cnt, exp_fb);
        end
        handshake("restart");
    endtask

    task automatic test_reset_mid_hold;
        bit got;
        got = 0;
        lit = '0;
        pick_next = 8'h83;
        dec_req = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            dec_req = 1'b0;
            if (dec_valid) begin got = 1; break; end
        end
        n_chk++;
        if (!got || dec_var !== 8'h83 || dec_pol !== 1'b1) begin
            n_fail++;
            $display("FAIL rsth_pre: got done=%0d var=%0h pol=%b want 1 83 1", got, dec_var, dec_pol);
        end
        #2 rst_n = 1'b0;
        #1;
        n_chk++;
        if ({dec_valid, dec_none, busy, pick_ena, dec_pol} !== 5'b0 || dec_var !== 8'd0
            || fallback_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL rsth_async: got v=%b var=%0d pol=%b busy=%b fb=%0d want all 0",
                     dec_valid, dec_var, dec_pol, busy, fallback_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || dec_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rsth_idle: got busy=%b v=%b want 0 0", busy, dec_valid);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        dec_req = 1'b0;
        dec_abort = 1'b0;
        dec_ready = 1'b0;
        lit = '0;
        pick_next = 8'd0;
        test_reset();
        test_hit_hold();
        test_fallback();
        test_none();
        test_live_recheck();
        test_abort();
        test_reset_mid_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
